// File: rtl/dice_roll_gen_pkg.sv
// Shared types and constants for the dice roll generator and its game-side interface.
package dice_pkg;

  localparam int DIE_W = 3;
  localparam int SUM_W = 4;

  localparam logic [DIE_W-1:0] DIE_MIN = DIE_W'(1);
  localparam logic [DIE_W-1:0] DIE_MAX = DIE_W'(6);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    TUMBLE  = 2'd1,
    PRESENT = 2'd2
  } state_e;

  // Next face of a die: 1..6 then back to 1, never 0 or 7.
  function automatic logic [DIE_W-1:0] die_step(input logic [DIE_W-1:0] d);
    return (d == DIE_MAX) ? DIE_MIN : d + DIE_W'(1);
  endfunction

endpackage

// File: rtl/dice_roll_gen_if.sv
// Result handshake between the dice producer and the game controller.
interface dice_roll_gen_if;
  import dice_pkg::*;

  logic             roll_valid;
  logic             roll_ack;
  logic [DIE_W-1:0] die1;
  logic [DIE_W-1:0] die2;
  logic [SUM_W-1:0] sum;

  modport master (output roll_valid, output die1, output die2, output sum, input roll_ack);
  modport slave  (input roll_valid, input die1, input die2, input sum, output roll_ack);
endinterface

// File: rtl/dice_roll_gen_debouncer.sv
// Two-flop synchronizer followed by a consecutive-sample stability filter.
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic din,
  output logic level
);
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_p0;
  logic             sync_p1;
  logic [CNT_W-1:0] stable_cnt;

  always_ff @(posedge clock) begin
    if (reset) begin
      sync_p0    <= 1'b0;
      sync_p1    <= 1'b0;
      stable_cnt <= '0;
      level      <= 1'b0;
    end else begin
      sync_p0 <= din;
      sync_p1 <= sync_p0;
      // A single sample agreeing with the current level restarts the count.
      if (sync_p1 != level) begin
        if (stable_cnt == CNT_LAST) begin
          level      <= ~level;
          stable_cnt <= '0;
        end else begin
          stable_cnt <= stable_cnt + CNT_W'(1);
        end
      end else begin
        stable_cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/dice_roll_gen.sv
// Dice producer: debounced roll button, free-running dice counters, tumble/present FSM
// and a valid/ack result handshake towards the game controller.
module dice_roll_gen
  import dice_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int TUMBLE_CYCLES   = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             roll,
  dice_roll_gen_if.master  game,
  output logic [DIE_W-1:0] disp_die1,
  output logic [DIE_W-1:0] disp_die2,
  output logic             busy
);
  localparam int TC_W = $clog2(TUMBLE_CYCLES + 1);
  localparam logic [TC_W-1:0] TC_MAX = TC_W'(TUMBLE_CYCLES);

  function automatic logic [SUM_W-1:0] dice_sum(input logic [DIE_W-1:0] a,
                                                input logic [DIE_W-1:0] b);
    return SUM_W'(a) + SUM_W'(b);
  endfunction

  logic             level;
  logic             level_q;
  logic             rise;
  state_e           state;
  state_e           state_nxt;
  logic             capture;
  logic [TC_W-1:0]  tcnt;
  logic [DIE_W-1:0] cnt1;
  logic [DIE_W-1:0] cnt2;
  logic [DIE_W-1:0] die1_q;
  logic [DIE_W-1:0] die2_q;
  logic [SUM_W-1:0] sum_q;
  logic             valid_q;
  logic             busy_q;

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debouncer (
    .clock (clock),
    .reset (reset),
    .din   (roll),
    .level (level)
  );

  // Only a fresh rising edge starts a roll; a press held across PRESENT is not one.
  assign rise = level & ~level_q;

  // Dice counters free-run in every state so the result depends on press timing.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt1 <= DIE_MIN;
      cnt2 <= DIE_MIN;
    end else begin
      cnt1 <= die_step(cnt1);
      if (cnt1 == DIE_MAX) cnt2 <= die_step(cnt2);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= IDLE;
      busy_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      busy_q <= (state_nxt != IDLE);
    end
  end

  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    case (state)
      IDLE:    if (rise) state_nxt = TUMBLE;
      TUMBLE:  if (!level && tcnt == TC_MAX) begin
                 state_nxt = PRESENT;
                 capture   = 1'b1;
               end
      PRESENT: if (game.roll_ack) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    disp_die1 = die1_q;
    disp_die2 = die2_q;
    if (state == TUMBLE) begin
      disp_die1 = cnt1;
      disp_die2 = cnt2;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      level_q <= 1'b0;
      tcnt    <= '0;
      die1_q  <= DIE_MIN;
      die2_q  <= DIE_MIN;
      sum_q   <= dice_sum(DIE_MIN, DIE_MIN);
      valid_q <= 1'b0;
    end else begin
      level_q <= level;
      if (state == IDLE) begin
        tcnt <= '0;
      end else if (state == TUMBLE && tcnt != TC_MAX) begin
        tcnt <= tcnt + TC_W'(1);
      end
      if (capture) begin
        die1_q  <= cnt1;
        die2_q  <= cnt2;
        sum_q   <= dice_sum(cnt1, cnt2);
        valid_q <= 1'b1;
      end else if (state == PRESENT && game.roll_ack) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign game.die1       = die1_q;
  assign game.die2       = die2_q;
  assign game.sum        = sum_q;
  assign game.roll_valid = valid_q;
  assign busy            = busy_q;

endmodule
